// File: rtl/axi4_test_ram.sv
// AXI4 slave test memory: word-addressed RAM behind independent write and
// read FSMs, returning SLVERR for non-INCR or non-32-bit bursts and flagging
// WLAST mismatches through a sticky protocol_error.
module axi4_test_ram #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_WORDS        = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWLOCK,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARLOCK,
  input  logic [3:0]                      S_AXI_ARCACHE,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic [3:0]                      S_AXI_ARQOS,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            protocol_error
);

  localparam int unsigned IDX_W  = $clog2(C_MEM_WORDS);
  localparam int unsigned NBYTES = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_WORDS];

  // Write channel state
  logic [1:0]                  w_state_q, w_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [IDX_W-1:0]            w_idx_q, w_idx_d;
  logic [7:0]                  w_len_q, w_len_d;
  logic [8:0]                  w_cnt_q, w_cnt_d;
  logic                        w_legal_q, w_legal_d;
  logic                        awready_q, awready_d;
  logic                        wready_q, wready_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        perr_q, perr_d;

  // Read channel state
  logic [1:0]                    r_state_q, r_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [IDX_W-1:0]              r_idx_q, r_idx_d;
  logic [7:0]                    r_len_q, r_len_d;
  logic [7:0]                    r_cnt_q, r_cnt_d;
  logic                          r_legal_q, r_legal_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic                          rlast_q, rlast_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
  logic w_final_c;
  logic unused_inputs;

  assign aw_hs_c = awready_q & S_AXI_AWVALID;
  assign w_hs_c  = wready_q  & S_AXI_WVALID;
  assign b_hs_c  = bvalid_q  & S_AXI_BREADY;
  assign ar_hs_c = arready_q & S_AXI_ARVALID;
  assign r_hs_c  = rvalid_q  & S_AXI_RREADY;

  assign w_final_c = (w_cnt_q == {1'b0, w_len_q});

  // Sideband AXI attributes and aliased address bits have no effect here
  assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWLOCK, S_AXI_AWCACHE,
                           S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_ARLOCK, S_AXI_ARCACHE,
                           S_AXI_ARPROT, S_AXI_ARQOS};

  // Write FSM next state: accept AW, absorb len+1 beats, then hold B
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_legal_d = w_legal_q;
    bresp_d   = bresp_q;
    perr_d    = perr_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          w_id_d    = S_AXI_AWID;
          w_idx_d   = S_AXI_AWADDR[IDX_W+1:2];
          w_len_d   = S_AXI_AWLEN;
          w_cnt_d   = 9'd0;
          w_legal_d = (S_AXI_AWBURST == BURST_INCR) && (S_AXI_AWSIZE == SIZE_4B);
          bresp_d   = ((S_AXI_AWBURST == BURST_INCR) && (S_AXI_AWSIZE == SIZE_4B))
                      ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs_c) begin
          w_idx_d = w_idx_q + IDX_W'(1);
          w_cnt_d = w_cnt_q + 9'd1;
          if (w_final_c != S_AXI_WLAST) perr_d = 1'b1;
          if (w_final_c) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs_c) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_legal_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      perr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_legal_q <= w_legal_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      perr_q    <= perr_d;
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_hs_c && w_legal_q) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM next state: fetch one word, present it, repeat until last
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_legal_d = r_legal_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_id_d    = S_AXI_ARID;
          r_idx_d   = S_AXI_ARADDR[IDX_W+1:2];
          r_len_d   = S_AXI_ARLEN;
          r_cnt_d   = 8'd0;
          r_legal_d = (S_AXI_ARBURST == BURST_INCR) && (S_AXI_ARSIZE == SIZE_4B);
          rresp_d   = ((S_AXI_ARBURST == BURST_INCR) && (S_AXI_ARSIZE == SIZE_4B))
                      ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rdata_d   = r_legal_q ? mem[r_idx_q] : '0;
        rlast_d   = (r_cnt_q == r_len_q);
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs_c) begin
          rlast_d = 1'b0;
          if (rlast_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d   = r_idx_q + IDX_W'(1);
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read FSM registers
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_legal_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_legal_q <= r_legal_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BID      = w_id_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RID      = r_id_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = rresp_q;
  assign S_AXI_RLAST    = rlast_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_axi4_test_ram.sv
// Directed plus randomized bench for axi4_test_ram against a word-array model.
module tb_axi4_test_ram;

  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache, awqos, arqos, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, perr;

  always #5 clk = ~clk;

  axi4_test_ram dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(awlock), .S_AXI_AWCACHE(awcache),
    .S_AXI_AWPROT(awprot), .S_AXI_AWQOS(awqos), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_ARLOCK(arlock), .S_AXI_ARCACHE(arcache), .S_AXI_ARPROT(arprot),
    .S_AXI_ARQOS(arqos), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .protocol_error(perr)
  );

  // Reference memory: value plus a flag saying the whole word is known
  bit [31:0]   mdl [WORDS];
  bit          mv  [WORDS];
  logic        exp_perr;
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b01) && (size == 3'b010);
  endfunction

  // Issue AW then nbeats W beats from wd/ws/wl; collect B if the burst completed
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input int nbeats, input bit gaps);
    int unsigned idx;
    int          cyc;
    bit          legal;
    legal   = is_legal(burst, size);
    idx     = (addr >> 2) % WORDS;
    awaddr  = addr; awlen = len; awsize = size; awburst = burst; awid = id;
    awlock  = 1'($urandom); awcache = 4'($urandom); awprot = 3'($urandom); awqos = 4'($urandom);
    awvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 50) begin tick(); cyc++; end
    if (cyc >= 50) chk("aw_timeout", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    chk("aw_wready", 32'({wready, awready}), 32'b10);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      if (legal && (mv[idx] || ws[i] == 4'hF)) begin
        for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[idx][8*b +: 8] = wd[i][8*b +: 8];
        mv[idx] = 1'b1;
      end
      if (wl[i] != (i == int'(len))) exp_perr = 1'b1;
      idx = (idx + 1) % WORDS;
      if (i < int'(len)) chk("w_bvalid_early", 32'(bvalid), 32'd0);
      else               chk("w_bvalid", 32'(bvalid), 32'd1);
    end
    if (nbeats < int'(len) + 1) return;
    chk("w_perr", 32'(perr), 32'(exp_perr));
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("b_hold", 32'(bvalid), 32'd1);
      end
    end
    bready = 1'b1;
    chk("b_resp", 32'({bid, bresp}), 32'({id, legal ? 2'b00 : 2'b10}));
    tick();
    bready = 1'b0;
    chk("b_done", 32'({bvalid, awready}), 32'b01);
  endtask

  // Issue AR and check every beat's data, response, RLAST and timing
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic id, input bit stall);
    int unsigned idx;
    int          cyc;
    bit          legal;
    logic [31:0] exp_d;
    legal   = is_legal(burst, size);
    idx     = (addr >> 2) % WORDS;
    araddr  = addr; arlen = len; arsize = size; arburst = burst; arid = id;
    arlock  = 1'($urandom); arcache = 4'($urandom); arprot = 3'($urandom); arqos = 4'($urandom);
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 50) begin tick(); cyc++; end
    if (cyc >= 50) chk("ar_timeout", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("ar_fetch", 32'({rvalid, arready}), 32'b00);
    for (int i = 0; i <= int'(len); i++) begin
      rready = !(stall && $urandom_range(0, 2) == 0);
      cyc = 0;
      do begin tick(); cyc++; end while (!rvalid && cyc < 50);
      chk("r_latency", 32'(cyc), 32'd1);
      chk("r_last", 32'(rlast), 32'(i == int'(len)));
      chk("r_resp", 32'({rid, rresp}), 32'({id, legal ? 2'b00 : 2'b10}));
      exp_d = legal ? mdl[idx] : 32'd0;
      if (!legal || mv[idx]) chk("r_data", rdata, exp_d);
      if (!rready) begin
        tick();
        chk("r_hold_valid", 32'({rvalid, rlast}), 32'({1'b1, i == int'(len)}));
        if (!legal || mv[idx]) chk("r_hold_data", rdata, exp_d);
        rready = 1'b1;
      end
      tick();
      rready = 1'b0;
      if (i < int'(len)) chk("r_gap", 32'(rvalid), 32'd0);
      else               chk("r_end", 32'({rvalid, arready}), 32'b01);
      idx = (idx + 1) % WORDS;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, 32'({awready, wready, bvalid, arready, rvalid, rlast, perr}), 32'd0);
    chk(tag, 32'({bresp, rresp, bid, rid}), 32'd0);
    chk(tag, rdata, 32'd0);
  endtask

  task automatic fill(input int n, input bit rnd_strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = $urandom;
      ws[i] = (rnd_strb && $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'hF;
      wl[i] = (i == n - 1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [1:0]  bu;
    logic [2:0]  sz;
    exp_perr = 1'b0;
    rst = 1'b1;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready} = '0;
    repeat (3) tick();
    chk_reset_outputs("reset_vals");
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'({awready, arready}), 32'b00);
    tick();
    chk("ready_first_edge", 32'({awready, arready}), 32'b11);

    // Basic 4-beat write and read-back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 3); end
    do_write(32'h100, 8'd3, 3'b010, 2'b01, 1'b1, 4, 1'b0);
    do_read(32'h100, 8'd3, 3'b010, 2'b01, 1'b1, 1'b0);

    // Byte-lane strobe merges into existing word: expect 0x0000FFA0
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0010; wl[0] = 1'b1;
    do_write(32'h100, 8'd0, 3'b010, 2'b01, 1'b0, 1, 1'b0);
    do_read(32'h100, 8'd0, 3'b010, 2'b01, 1'b0, 1'b0);
    chk("strb_word", mdl[32'h40], 32'h0000_FFA0);

    // Illegal bursts: FIXED write suppressed, narrow read gives SLVERR/0
    fill(2, 1'b0);
    do_write(32'h100, 8'd1, 3'b010, 2'b00, 1'b1, 2, 1'b0);
    do_read(32'h100, 8'd1, 3'b010, 2'b01, 1'b1, 1'b0);
    do_read(32'h100, 8'd1, 3'b001, 2'b01, 1'b0, 1'b0);

    // Wrap from the top word to word 0
    fill(2, 1'b0);
    do_write(32'((WORDS - 1) * 4), 8'd1, 3'b010, 2'b01, 1'b0, 2, 1'b0);
    do_read(32'((WORDS - 1) * 4), 8'd1, 3'b010, 2'b01, 1'b0, 1'b0);

    // Early WLAST: burst still runs to len+1 and protocol_error sticks
    fill(3, 1'b0);
    wl[1] = 1'b1; wl[2] = 1'b0;
    do_write(32'h200, 8'd2, 3'b010, 2'b01, 1'b1, 3, 1'b0);
    chk("perr_sticky", 32'(perr), 32'd1);

    // Reset in the middle of an 8-beat burst
    fill(8, 1'b0);
    do_write(32'h300, 8'd7, 3'b010, 2'b01, 1'b1, 3, 1'b0);
    rst = 1'b1;
    #2;
    chk_reset_outputs("reset_mid_burst");
    exp_perr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("ready_after_mid_reset", 32'({awready, arready}), 32'b11);
    fill(4, 1'b0);
    do_write(32'h340, 8'd3, 3'b010, 2'b01, 1'b0, 4, 1'b0);
    do_read(32'h340, 8'd3, 3'b010, 2'b01, 1'b0, 1'b0);
    do_read(32'h100, 8'd3, 3'b010, 2'b01, 1'b1, 1'b0);
    do_read(32'((WORDS - 1) * 4), 8'd1, 3'b010, 2'b01, 1'b0, 1'b0);
    do_read(32'h300, 8'd7, 3'b010, 2'b01, 1'b1, 1'b0);

    // Randomized traffic with aliased upper address bits; first burst is 256 beats
    for (int k = 0; k < 20; k++) begin
      a  = $urandom;
      l  = (k == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      bu = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      fill(int'(l) + 1, k > 0);
      do_write(a, l, sz, bu, 1'($urandom), int'(l) + 1, 1'b1);
      do_read(a ^ ($urandom << 12), l, 3'b010, 2'b01, 1'($urandom), 1'b1);
    end
    chk("perr_final", 32'(perr), 32'(exp_perr));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
